// File: rtl/rt_acq_thresh_mon.sv
// Acquisition queue occupancy tracker with filtered high/low water flags and sticky over/underflow.
// Optional triple-redundant occupancy counter enabled by defining ACQ_CNT_TMR_EN.
module rt_acq_thresh_mon #(
  parameter int unsigned CNT_W = 6,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned FILT  = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             acq_push,
  input  logic             acq_pop,
  input  logic [CNT_W-1:0] thr_hi,
  input  logic [CNT_W-1:0] thr_lo,
  output logic             acq_thresh_hi,
  output logic             acq_thresh_lo,
  output logic [CNT_W-1:0] acq_level,
  output logic             acq_ovf,
  output logic             acq_udf,
  output logic             cfg_err,
  output logic             tmr_err
);

  localparam int unsigned FLT_W = (FILT < 2) ? 1 : $clog2(FILT + 1);
  localparam logic [CNT_W-1:0] DEPTH_L = CNT_W'(DEPTH);
  localparam logic [FLT_W-1:0] FILT_L  = FLT_W'(FILT);

  logic [CNT_W-1:0] lvl_cur;
  logic [CNT_W-1:0] lvl_nxt;
  logic             push_only;
  logic             pop_only;
  logic             at_full;
  logic             at_empty;
  logic             cfg_bad;
  logic [FLT_W-1:0] hi_cnt;
  logic [FLT_W-1:0] lo_cnt;
  logic [FLT_W-1:0] hi_cnt_nxt;
  logic [FLT_W-1:0] lo_cnt_nxt;

  // Simultaneous push and pop is a pass-through, even at the queue limits.
  always_comb begin
    push_only = acq_push & ~acq_pop;
    pop_only  = acq_pop & ~acq_push;
    at_full   = (lvl_cur == DEPTH_L);
    at_empty  = (lvl_cur == '0);
    lvl_nxt   = lvl_cur;
    if (push_only && !at_full) begin
      lvl_nxt = lvl_cur + CNT_W'(1);
    end else if (pop_only && !at_empty) begin
      lvl_nxt = lvl_cur - CNT_W'(1);
    end
  end

  // Saturating run-length of a held condition; a misconfigured threshold pair forces it idle.
  function automatic logic [FLT_W-1:0] filt_next(input logic cond, input logic bad,
                                                 input logic [FLT_W-1:0] cnt);
    if (bad || !cond) begin
      return '0;
    end else if (cnt == FILT_L) begin
      return cnt;
    end else begin
      return cnt + FLT_W'(1);
    end
  endfunction

  always_comb begin
    cfg_bad    = (thr_lo >= thr_hi);
    hi_cnt_nxt = filt_next(lvl_cur >= thr_hi, cfg_bad, hi_cnt);
    lo_cnt_nxt = filt_next(lvl_cur <= thr_lo, cfg_bad, lo_cnt);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hi_cnt        <= '0;
      lo_cnt        <= '0;
      acq_thresh_hi <= 1'b0;
      acq_thresh_lo <= 1'b0;
      acq_ovf       <= 1'b0;
      acq_udf       <= 1'b0;
      cfg_err       <= 1'b0;
    end else begin
      hi_cnt        <= hi_cnt_nxt;
      lo_cnt        <= lo_cnt_nxt;
      acq_thresh_hi <= (hi_cnt_nxt == FILT_L);
      acq_thresh_lo <= (lo_cnt_nxt == FILT_L);
      acq_ovf       <= acq_ovf | (push_only & at_full);
      acq_udf       <= acq_udf | (pop_only & at_empty);
      cfg_err       <= cfg_bad;
    end
  end

`ifdef ACQ_CNT_TMR_EN
  logic [CNT_W-1:0] cp_a;
  logic [CNT_W-1:0] cp_b;
  logic [CNT_W-1:0] cp_c;

  // Every copy reloads from the voted next value, so a single upset heals in one edge.
  assign lvl_cur   = (cp_a & cp_b) | (cp_a & cp_c) | (cp_b & cp_c);
  assign acq_level = lvl_cur;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cp_a    <= '0;
      cp_b    <= '0;
      cp_c    <= '0;
      tmr_err <= 1'b0;
    end else begin
      cp_a    <= lvl_nxt;
      cp_b    <= lvl_nxt;
      cp_c    <= lvl_nxt;
      tmr_err <= (cp_a != lvl_cur) | (cp_b != lvl_cur) | (cp_c != lvl_cur);
    end
  end
`else
  logic [CNT_W-1:0] lvl_q;

  assign lvl_cur   = lvl_q;
  assign acq_level = lvl_q;
  assign tmr_err   = 1'b0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lvl_q <= '0;
    end else begin
      lvl_q <= lvl_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_rt_acq_thresh_mon.sv
// Randomised and directed bench for rt_acq_thresh_mon against an integer reference model.
module tb_rt_acq_thresh_mon;

  localparam int unsigned CNT_W = 6;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned FILT  = 2;
  localparam int unsigned VW    = CNT_W + 6;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             acq_push;
  logic             acq_pop;
  logic [CNT_W-1:0] thr_hi;
  logic [CNT_W-1:0] thr_lo;
  logic             acq_thresh_hi;
  logic             acq_thresh_lo;
  logic [CNT_W-1:0] acq_level;
  logic             acq_ovf;
  logic             acq_udf;
  logic             cfg_err;
  logic             tmr_err;

  int checks = 0;
  int errors = 0;

  // Reference state
  int m_lvl, m_hic, m_loc;
  bit m_hi, m_lo, m_ovf, m_udf, m_cfg;

  rt_acq_thresh_mon #(.CNT_W(CNT_W), .DEPTH(DEPTH), .FILT(FILT)) dut (
    .clk(clk), .reset_n(reset_n), .acq_push(acq_push), .acq_pop(acq_pop),
    .thr_hi(thr_hi), .thr_lo(thr_lo), .acq_thresh_hi(acq_thresh_hi),
    .acq_thresh_lo(acq_thresh_lo), .acq_level(acq_level), .acq_ovf(acq_ovf),
    .acq_udf(acq_udf), .cfg_err(cfg_err), .tmr_err(tmr_err)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] obs_vec();
    return {acq_level, acq_thresh_hi, acq_thresh_lo, acq_ovf, acq_udf, cfg_err, tmr_err};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {CNT_W'(m_lvl), m_hi, m_lo, m_ovf, m_udf, m_cfg, 1'b0};
  endfunction

  // Apply inputs for one edge and advance the model from the pre-edge state.
  task automatic cycle(input bit rst, input bit push, input bit pop);
    bit bad, hcond, lcond;
    reset_n  = ~rst;
    acq_push = push;
    acq_pop  = pop;
    @(posedge clk);
    if (rst) begin
      m_lvl = 0; m_hic = 0; m_loc = 0;
      m_hi = 0; m_lo = 0; m_ovf = 0; m_udf = 0; m_cfg = 0;
    end else begin
      bad   = (int'(thr_lo) >= int'(thr_hi));
      hcond = (m_lvl >= int'(thr_hi));
      lcond = (m_lvl <= int'(thr_lo));
      m_hic = (bad || !hcond) ? 0 : ((m_hic + 1 > FILT) ? FILT : m_hic + 1);
      m_loc = (bad || !lcond) ? 0 : ((m_loc + 1 > FILT) ? FILT : m_loc + 1);
      m_hi  = (m_hic == FILT);
      m_lo  = (m_loc == FILT);
      m_cfg = bad;
      if (push && !pop) begin
        if (m_lvl == DEPTH) m_ovf = 1; else m_lvl++;
      end else if (pop && !push) begin
        if (m_lvl == 0) m_udf = 1; else m_lvl--;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    thr_hi = 6'd24; thr_lo = 6'd8;
    repeat (2) cycle(1, 1, 0);
    checks++;
    if (obs_vec() !== '0) begin
      errors++;
      $display("FAIL reset_state got %h expected %h", obs_vec(), '0);
    end
  endtask

  task automatic test_fill_hi();
    for (int i = 1; i <= 24; i++) begin
      cycle(0, 1, 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL fill_step%0d got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (acq_level !== 6'd24 || acq_thresh_lo !== 1'b0) begin
      errors++;
      $display("FAIL fill_level24 got lvl=%0d lo=%b expected lvl=24 lo=0", acq_level, acq_thresh_lo);
    end
    cycle(0, 0, 0);
    checks++;
    if (acq_thresh_hi !== 1'b0) begin
      errors++;
      $display("FAIL hi_early got %b expected 0", acq_thresh_hi);
    end
    cycle(0, 0, 0);
    checks++;
    if (acq_thresh_hi !== 1'b1) begin
      errors++;
      $display("FAIL hi_filt got %b expected 1", acq_thresh_hi);
    end
  endtask

  task automatic test_pop_hi();
    cycle(0, 0, 1);
    cycle(0, 0, 0);
    checks++;
    if (acq_thresh_hi !== 1'b0 || acq_level !== 6'd23) begin
      errors++;
      $display("FAIL hi_drop got hi=%b lvl=%0d expected hi=0 lvl=23", acq_thresh_hi, acq_level);
    end
    cycle(0, 1, 0);
    cycle(0, 0, 0);
    checks++;
    if (acq_thresh_hi !== 1'b0) begin
      errors++;
      $display("FAIL hi_rearm_early got %b expected 0", acq_thresh_hi);
    end
    cycle(0, 0, 0);
    checks++;
    if (acq_thresh_hi !== 1'b1 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL hi_rearm got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_ovf_udf();
    while (m_lvl < DEPTH) cycle(0, 1, 0);
    checks++;
    if (acq_ovf !== 1'b0 || acq_level !== 6'd32) begin
      errors++;
      $display("FAIL full got ovf=%b lvl=%0d expected ovf=0 lvl=32", acq_ovf, acq_level);
    end
    cycle(0, 1, 1);
    checks++;
    if (acq_ovf !== 1'b0 || acq_level !== 6'd32) begin
      errors++;
      $display("FAIL pass_full got ovf=%b lvl=%0d expected ovf=0 lvl=32", acq_ovf, acq_level);
    end
    cycle(0, 1, 0);
    checks++;
    if (acq_ovf !== 1'b1 || acq_level !== 6'd32) begin
      errors++;
      $display("FAIL ovf got ovf=%b lvl=%0d expected ovf=1 lvl=32", acq_ovf, acq_level);
    end
    while (m_lvl > 0) cycle(0, 0, 1);
    cycle(0, 1, 1);
    checks++;
    if (acq_udf !== 1'b0 || acq_level !== 6'd0) begin
      errors++;
      $display("FAIL pass_empty got udf=%b lvl=%0d expected udf=0 lvl=0", acq_udf, acq_level);
    end
    cycle(0, 0, 1);
    checks++;
    if (acq_udf !== 1'b1 || acq_ovf !== 1'b1 || acq_level !== 6'd0) begin
      errors++;
      $display("FAIL udf got udf=%b ovf=%b lvl=%0d expected 1 1 0", acq_udf, acq_ovf, acq_level);
    end
  endtask

  task automatic test_cfg_err();
    repeat (3) cycle(0, 0, 0);
    thr_lo = 6'd24;
    cycle(0, 0, 0);
    checks++;
    if (cfg_err !== 1'b1 || acq_thresh_hi !== 1'b0 || acq_thresh_lo !== 1'b0) begin
      errors++;
      $display("FAIL cfg_set got cfg=%b hi=%b lo=%b expected 1 0 0", cfg_err, acq_thresh_hi, acq_thresh_lo);
    end
    thr_lo = 6'd8;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL cfg_clear%0d got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    while (m_lvl < 17) cycle(0, 1, 0);
    cycle(1, 1, 0);
    checks++;
    if (obs_vec() !== '0) begin
      errors++;
      $display("FAIL reset_mid got %h expected %h", obs_vec(), '0);
    end
    cycle(0, 1, 0);
    checks++;
    if (acq_level !== 6'd1) begin
      errors++;
      $display("FAIL reset_recount got %0d expected 1", acq_level);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        thr_hi = CNT_W'($urandom_range(0, 40));
        thr_lo = CNT_W'($urandom_range(0, 40));
      end
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL rand%0d got %h expected %h", i, obs_vec(), exp_vec());
      end
      checks++;
      if ((acq_thresh_hi & acq_thresh_lo) !== 1'b0) begin
        errors++;
        $display("FAIL excl%0d got hi=%b lo=%b expected not both", i, acq_thresh_hi, acq_thresh_lo);
      end
    end
    // Long drift toward full and empty to exercise the limits under random traffic.
    thr_hi = 6'd24; thr_lo = 6'd8;
    for (int i = 0; i < 200; i++) begin
      cycle(0, (i < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
               (i < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL drift%0d got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; acq_push = 1'b0; acq_pop = 1'b0;
    thr_hi = 6'd24; thr_lo = 6'd8;
    test_reset();
    test_fill_hi();
    test_pop_hi();
    test_ovf_udf();
    test_cfg_err();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
